// File: rtl/clock_pkg.sv
// Shared constants for the time-of-day counter: BCD digit width and per-field maxima.
package clock_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX with synchronous clear, increment and carry at MAX->00.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] tens,
  output logic             carry_c
);

  localparam logic [BCD_W-1:0] MAX_T = BCD_W'(MAX / 10);
  localparam logic [BCD_W-1:0] MAX_O = BCD_W'(MAX % 10);
  localparam logic [BCD_W-1:0] NINE  = BCD_W'(9);

  logic at_max_c;

  assign at_max_c = (tens == MAX_T) && (ones == MAX_O);
  assign carry_c  = inc && !clr && at_max_c;

  // Clear wins over increment; full-range wrap takes precedence over units wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones <= '0;
      tens <= '0;
    end else if (clr) begin
      ones <= '0;
      tens <= '0;
    end else if (inc) begin
      if (at_max_c) begin
        ones <= '0;
        tens <= '0;
      end else if (ones == NINE) begin
        ones <= '0;
        tens <= tens + BCD_W'(1);
      end else begin
        ones <= ones + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS BCD time-of-day counter with 1 Hz prescaler, colon blink,
// manual minute/hour set and hour/day roll-over pulses.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned DIV   = 100_000_000,
  parameter int unsigned DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             inc_min,
  input  logic             inc_hr,
  output logic [BCD_W-1:0] sec_o,
  output logic [BCD_W-1:0] sec_t,
  output logic [BCD_W-1:0] min_o,
  output logic [BCD_W-1:0] min_t,
  output logic [BCD_W-1:0] hr_o,
  output logic [BCD_W-1:0] hr_t,
  output logic             tick,
  output logic             colon,
  output logic             chime,
  output logic             day_wrap
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] CNT_HALF = DIV_W'(DIV / 2);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next_c;
  logic             adv_c;
  logic             sec_cy_c;
  logic             min_cy_c;
  logic             hr_cy_c;

  // tick and colon are registered from the next count so they line up with it.
  always_comb begin
    cnt_next_c = cnt;
    if (run) begin
      cnt_next_c = (cnt == CNT_LAST) ? '0 : cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      tick  <= 1'b0;
      colon <= 1'b1;
    end else begin
      cnt   <= cnt_next_c;
      tick  <= run && (cnt_next_c == CNT_LAST);
      colon <= cnt_next_c < CNT_HALF;
    end
  end

  // A manual set in a tick cycle swallows that second's advance.
  assign adv_c = tick && !inc_min && !inc_hr;

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .inc     (adv_c),
    .clr     (inc_min),
    .ones    (sec_o),
    .tens    (sec_t),
    .carry_c (sec_cy_c)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc_min || sec_cy_c),
    .clr     (1'b0),
    .ones    (min_o),
    .tens    (min_t),
    .carry_c (min_cy_c)
  );

  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc_hr || (sec_cy_c && min_cy_c)),
    .clr     (1'b0),
    .ones    (hr_o),
    .tens    (hr_t),
    .carry_c (hr_cy_c)
  );

  // sec_cy_c only fires on a tick advance, so manual sets never reach these pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chime    <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      chime    <= sec_cy_c && min_cy_c;
      day_wrap <= sec_cy_c && min_cy_c && hr_cy_c;
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter: seconds-of-day reference model plus directed table.
module tb_bcd_time_counter;

  localparam int unsigned DIV   = 4;
  localparam int unsigned DIV_W = 3;
  localparam int NV = 23;

  logic       clk, rst, run, inc_min, inc_hr;
  logic [3:0] sec_o, sec_t, min_o, min_t, hr_o, hr_t;
  logic       tick, colon, chime, day_wrap;

  bcd_time_counter #(.DIV(DIV), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .inc_min  (inc_min),
    .inc_hr   (inc_hr),
    .sec_o    (sec_o),
    .sec_t    (sec_t),
    .min_o    (min_o),
    .min_t    (min_t),
    .hr_o     (hr_o),
    .hr_t     (hr_t),
    .tick     (tick),
    .colon    (colon),
    .chime    (chime),
    .day_wrap (day_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: time as seconds of day, prescaler as plain integer.
  int m_t, m_p;
  bit m_tick, m_colon, m_chime, m_dw;

  typedef struct {
    logic run;
    logic im;
    logic ih;
    int   cyc;
    int   h;
    int   m;
    int   s;
    logic ch;
    logic dw;
  } vec_t;

  vec_t tbl [NV];

  function automatic logic [23:0] digits(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] dut_digits();
    return {hr_t, hr_o, min_t, min_o, sec_t, sec_o};
  endfunction

  task automatic model_reset();
    m_t = 0; m_p = 0; m_tick = 0; m_colon = 1; m_chime = 0; m_dw = 0;
  endtask

  task automatic model_update(input logic r, input logic im, input logic ih);
    int h, m, s;
    bit adv;
    adv = m_tick && !im && !ih;
    m_chime = 0;
    m_dw = 0;
    if (adv) begin
      m_chime = (m_t % 3600) == 3599;
      m_dw    = (m_t == 86399);
      m_t     = (m_t + 1) % 86400;
    end
    h = m_t / 3600;
    m = (m_t / 60) % 60;
    s = m_t % 60;
    if (im) begin
      m = (m + 1) % 60;
      s = 0;
    end
    if (ih) h = (h + 1) % 24;
    m_t = h * 3600 + m * 60 + s;
    if (r) m_p = (m_p + 1) % DIV;
    m_tick  = r && (m_p == DIV - 1);
    m_colon = m_p < DIV / 2;
  endtask

  task automatic check_model(input string name);
    logic [27:0] act, exp;
    act = {dut_digits(), tick, colon, chime, day_wrap};
    exp = {digits(m_t), m_tick, m_colon, m_chime, m_dw};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h (hhmmss_tick_colon_chime_dw)", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic im, input logic ih, input string name);
    run = r; inc_min = im; inc_hr = ih;
    @(posedge clk);
    model_update(r, im, ih);
    #1;
    check_model(name);
  endtask

  task automatic check_tbl(input int i);
    logic [25:0] act, exp;
    act = {dut_digits(), chime, day_wrap};
    exp = {4'(tbl[i].h / 10), 4'(tbl[i].h % 10), 4'(tbl[i].m / 10), 4'(tbl[i].m % 10),
           4'(tbl[i].s / 10), 4'(tbl[i].s % 10), tbl[i].ch, tbl[i].dw};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL table[%0d]: got %h expected %h (hhmmss_chime_dw)", i, act, exp);
    end
  endtask

  initial begin
    //          run im ih  cyc  hh mm ss ch dw
    tbl[0]  = '{1, 0, 0, 240,  0, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 0,  58,  0,59, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 236,  0,59,59, 0, 0};
    tbl[3]  = '{1, 0, 0,   4,  1, 0, 0, 1, 0};
    tbl[4]  = '{1, 0, 0,   1,  1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 1,  22, 23, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0,  59, 23,59, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 235, 23,59,59, 0, 0};
    tbl[8]  = '{1, 0, 0,   4,  0, 0, 0, 1, 1};
    tbl[9]  = '{0, 0, 1,  12, 12, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 0,  59, 12,59, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 120, 12,59,30, 0, 0};
    tbl[12] = '{1, 1, 0,   1, 12, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 0,   5, 12, 5, 0, 0, 0};
    tbl[14] = '{0, 0, 1,  11, 23, 5, 0, 0, 0};
    tbl[15] = '{0, 0, 1,   1,  0, 5, 0, 0, 0};
    tbl[16] = '{0, 1, 0,  55,  0, 0, 0, 0, 0};
    tbl[17] = '{1, 0, 0,  19,  0, 0, 5, 0, 0};
    tbl[18] = '{1, 0, 0,   3,  0, 0, 5, 0, 0};
    tbl[19] = '{1, 1, 0,   1,  0, 1, 0, 0, 0};
    tbl[20] = '{1, 0, 0,   1,  0, 1, 0, 0, 0};
    tbl[21] = '{0, 1, 1,   1,  1, 2, 0, 0, 0};
    tbl[22] = '{0, 0, 0,  20,  1, 2, 0, 0, 0};

    rst = 1'b1; run = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset_state");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      for (int c = 0; c < tbl[i].cyc; c++) begin
        step(tbl[i].run, (c == 0 || tbl[i].im) ? tbl[i].im : 1'b0, tbl[i].ih, "model_table");
      end
      check_tbl(i);
    end

    // Reset asserted between edges must clear everything without waiting for a clock.
    step(1'b1, 1'b0, 1'b0, "pre_reset");
    step(1'b1, 1'b0, 1'b0, "pre_reset");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model("async_reset");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_model("reset_hold");
    end
    rst = 1'b0;

    // Random run/set traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) != 0, ($urandom % 24) == 0, ($urandom % 24) == 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
